// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM encoding and default operand width for the shift-add multiplier
package mul_pkg;
    localparam int DEFAULT_WIDTH = 64;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mul_shift_add_if.sv
// mul_shift_add_if: request/response handshake bundle for the shift-add multiplier
interface mul_shift_add_if import mul_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
    logic flush, in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] product;
    modport master (
        output flush, in_valid, a, b, a_signed, b_signed, out_ready,
        input in_ready, out_valid, product
    );
    modport slave (
        input flush, in_valid, a, b, a_signed, b_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mul_step.sv
// mul_step: one radix-2 shift-add step; accumulator bit 0 is dropped by the shift so it is not an input
module mul_step import mul_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
    input  logic [2*WIDTH-1:1] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               add,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, add ? mcand : {WIDTH{1'b0}}};
        acc_next = {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/mul_shift_add.sv
// mul_shift_add: sequential sign-magnitude shift-add multiplier with valid/ready handshake
module mul_shift_add import mul_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
    input logic clk,
    input logic rst,
    mul_shift_add_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] mcand, mplier;
    logic sign, a_neg, b_neg;
    assign a_neg = bus.a_signed & bus.a[WIDTH-1];
    assign b_neg = bus.b_signed & bus.b[WIDTH-1];
    mul_step #(.WIDTH(WIDTH)) step (
        .acc(acc[2*WIDTH-1:1]),
        .mcand(mcand),
        .add(mplier[0]),
        .acc_next(acc_next)
    );
    // Negating the most-negative value yields 2^(WIDTH-1), which fits as an unsigned magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            sign <= 1'b0;
            bus.product <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    mcand <= a_neg ? -bus.a : bus.a;
                    mplier <= b_neg ? -bus.b : bus.b;
                    sign <= a_neg ^ b_neg;
                    acc <= '0;
                    cnt <= '0;
                    bus.in_ready <= 1'b0;
                    state <= CALC;
                end
                CALC: begin
                    acc <= acc_next;
                    mplier <= mplier >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    bus.product <= sign ? -acc : acc;
                    bus.out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
